// File: rtl/tl45_memory.sv
// tl45_memory: memory-access stage of the TL45 pipeline.
// LW/SW run a single word-wide pipelined-Wishbone cycle and stall upstream until it
// completes; every other opcode passes through with one register of latency.
// Optional feature: define TL45_MEM_TIMEOUT_EN to abandon a bus cycle after
// TIMEOUT_CYCLES cycles in WAIT without ack/err.
module tl45_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [31:0] i_value,
  input  logic [31:0] i_st_val,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [3:0]  o_of_reg,
  output logic [31:0] o_of_val,
  output logic [3:0]  o_dr,
  output logic [31:0] o_value,
  output logic        o_bus_err
);

  localparam logic [4:0] OpLw = 5'h14;
  localparam logic [4:0] OpSw = 5'h15;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  dr_q, dr_d;
  logic        we_q, we_d;
  logic        flush_q, flush_d;
  // One-entry holding register for a response that arrives while downstream stalls.
  logic        hold_valid_q, hold_valid_d;
  logic        hold_err_q, hold_err_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  dr_out_q;
  logic [31:0] value_out_q;
  logic        bus_err_q;

  logic        is_mem, aligned, timeout;
  logic        out_wr, err_pulse, commit, c_err;
  logic [3:0]  out_dr;
  logic [31:0] out_val, c_data;

  assign is_mem  = (i_opcode == OpLw) || (i_opcode == OpSw);
  assign aligned = (i_value[1:0] == 2'b00);

`ifdef TL45_MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout = (state_q == StWait) && !hold_valid_q &&
                   (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter is zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StWait && !hold_valid_q) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tmo_cnt_q <= '0;
    else            tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  // Next-state, output-register write and forwarding decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dr_d         = dr_q;
    we_d         = we_q;
    flush_d      = flush_q;
    hold_valid_d = hold_valid_q;
    hold_err_d   = hold_err_q;
    hold_data_d  = hold_data_q;
    out_wr       = 1'b0;
    out_dr       = '0;
    out_val      = '0;
    err_pulse    = 1'b0;
    o_of_reg     = '0;
    o_of_val     = '0;
    commit       = 1'b0;
    c_err        = 1'b0;
    c_data       = '0;
    unique case (state_q)
      StIdle: begin
        if (i_pipe_flush) begin
          out_wr = 1'b1;
        end else if (!i_pipe_stall) begin
          if (is_mem && aligned) begin
            addr_d  = i_value[31:2];
            data_d  = i_st_val;
            dr_d    = i_dr;
            we_d    = (i_opcode == OpSw);
            flush_d = 1'b0;
            state_d = StReq;
          end else if (is_mem) begin
            err_pulse = 1'b1;
            out_wr    = 1'b1;
          end else begin
            out_wr  = 1'b1;
            out_dr  = i_dr;
            out_val = i_value;
          end
        end
        if (!is_mem) begin
          o_of_reg = i_dr;
          o_of_val = i_value;
        end
      end
      StReq: begin
        // The strobe has not been accepted yet, so a flush may simply abandon it.
        if (i_pipe_flush) begin
          state_d = StIdle;
          out_wr  = 1'b1;
        end else if (!i_wb_stall) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_pipe_flush) flush_d = 1'b1;
        if (hold_valid_q) begin
          if (!i_pipe_stall) begin
            commit = 1'b1;
            c_err  = hold_err_q;
            c_data = hold_data_q;
          end
        end else if (i_wb_ack || i_wb_err || timeout) begin
          if (i_pipe_stall) begin
            hold_valid_d = 1'b1;
            hold_err_d   = i_wb_err || timeout;
            hold_data_d  = i_wb_data;
          end else begin
            commit = 1'b1;
            c_err  = i_wb_err || timeout;
            c_data = i_wb_data;
          end
        end
        if (commit) begin
          state_d      = StIdle;
          hold_valid_d = 1'b0;
          flush_d      = 1'b0;
          out_wr       = 1'b1;
          if (c_err) begin
            err_pulse = 1'b1;
          end else if (!we_q && !flush_q && !i_pipe_flush) begin
            out_dr   = dr_q;
            out_val  = c_data;
            o_of_reg = dr_q;
            o_of_val = c_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage state and transaction latches.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      dr_q         <= '0;
      we_q         <= 1'b0;
      flush_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      dr_q         <= dr_d;
      we_q         <= we_d;
      flush_q      <= flush_d;
      hold_valid_q <= hold_valid_d;
      hold_err_q   <= hold_err_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // Writeback registers and bus-error pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dr_out_q    <= '0;
      value_out_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= err_pulse;
      if (out_wr) begin
        dr_out_q    <= out_dr;
        value_out_q <= out_val;
      end
    end
  end

  // Strobe is gated by flush so a strobe the stage is abandoning can never be accepted.
  assign o_wb_stb     = (state_q == StReq) && !i_pipe_flush;
  assign o_wb_cyc     = o_wb_stb || ((state_q == StWait) && !hold_valid_q);
  assign o_wb_we      = we_q && o_wb_cyc;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = 4'hF;
  assign o_pipe_flush = i_pipe_flush;
  assign o_pipe_stall = i_pipe_stall ||
                        ((state_q == StIdle) && is_mem && aligned && !i_pipe_flush) ||
                        (state_q == StReq) ||
                        ((state_q == StWait) && !commit);
  assign o_dr         = dr_out_q;
  assign o_value      = value_out_q;
  assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_tl45_memory.sv
// Directed self-checking bench for tl45_memory.
// Define TL45_MEM_TIMEOUT_EN to build both DUT and bench with the timeout feature.
module tb_tl45_memory;

`ifdef TL45_MEM_TIMEOUT_EN
  localparam int unsigned TbTmo = 4;
`else
  localparam int unsigned TbTmo = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_stall = 1'b0, pipe_flush = 1'b0;
  logic        o_pipe_stall, o_pipe_flush;
  logic [4:0]  opcode = '0;
  logic [3:0]  dr = '0;
  logic [31:0] value = '0, st_val = '0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdata = '0;
  logic [3:0]  of_reg, o_dr;
  logic [31:0] of_val, o_value;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tl45_memory #(.TIMEOUT_CYCLES(TbTmo)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_pipe_stall(pipe_stall), .i_pipe_flush(pipe_flush),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
    .i_opcode(opcode), .i_dr(dr), .i_value(value), .i_st_val(st_val),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
    .o_of_reg(of_reg), .o_of_val(of_val),
    .o_dr(o_dr), .o_value(o_value), .o_bus_err(bus_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    opcode = '0; dr = '0; value = '0; st_val = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    pipe_stall = 1'b0; pipe_flush = 1'b0;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [3:0] d, input logic [31:0] v);
    opcode = op; dr = d; value = v;
  endtask

  // Non-memory op for one cycle to load o_dr/o_value with a known value.
  task automatic preload(input logic [3:0] d, input logic [31:0] v);
    drive_op(5'h1, d, v);
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin
      $display("FAIL reset_bus cyc/stb/we=%b%b%b expected 000", wb_cyc, wb_stb, wb_we);
      miscompares++;
    end
    vectors++;
    if (o_dr !== 4'h0 || o_value !== 32'h0 || bus_err !== 1'b0) begin
      $display("FAIL reset_out dr=%h value=%h err=%b expected 0/0/0", o_dr, o_value, bus_err);
      miscompares++;
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (o_pipe_stall !== 1'b0) begin
      $display("FAIL reset_stall got %b expected 0", o_pipe_stall);
      miscompares++;
    end
  endtask

  task automatic test_passthrough();
    drive_op(5'h1, 4'd3, 32'h1234);
    #1;
    vectors++;
    if (of_reg !== 4'd3 || of_val !== 32'h1234) begin
      $display("FAIL pass_fwd reg=%h val=%h expected 3/00001234", of_reg, of_val);
      miscompares++;
    end
    step();
    vectors++;
    if (o_dr !== 4'd3 || o_value !== 32'h1234 || wb_cyc !== 1'b0) begin
      $display("FAIL pass_out dr=%h value=%h cyc=%b expected 3/00001234/0",
               o_dr, o_value, wb_cyc);
      miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_load();
    drive_op(5'h14, 4'd5, 32'h100);
    #1;
    vectors++;
    if (o_pipe_stall !== 1'b1) begin
      $display("FAIL load_stall0 got %b expected 1", o_pipe_stall);
      miscompares++;
    end
    step();
    vectors++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b0 || wb_addr !== 30'h40 ||
        wb_sel !== 4'hF || o_pipe_stall !== 1'b1) begin
      $display("FAIL load_req cyc=%b stb=%b we=%b addr=%h sel=%h stall=%b exp 1/1/0/40/f/1",
               wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, o_pipe_stall);
      miscompares++;
    end
    step();
    wb_ack = 1'b1; wb_rdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b0 || o_pipe_stall !== 1'b0) begin
      $display("FAIL load_wait cyc=%b stb=%b stall=%b expected 1/0/0",
               wb_cyc, wb_stb, o_pipe_stall);
      miscompares++;
    end
    vectors++;
    if (of_reg !== 4'd5 || of_val !== 32'hDEADBEEF) begin
      $display("FAIL load_fwd reg=%h val=%h expected 5/deadbeef", of_reg, of_val);
      miscompares++;
    end
    step();
    vectors++;
    if (o_dr !== 4'd5 || o_value !== 32'hDEADBEEF || wb_cyc !== 1'b0) begin
      $display("FAIL load_out dr=%h value=%h cyc=%b expected 5/deadbeef/0",
               o_dr, o_value, wb_cyc);
      miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_store_stall();
    drive_op(5'h15, 4'd7, 32'h200);
    st_val = 32'hCAFE; wb_stall = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wb_stb !== 1'b1 || wb_we !== 1'b1 || wb_wdata !== 32'hCAFE || wb_addr !== 30'h80) begin
        $display("FAIL store_req%0d stb=%b we=%b data=%h addr=%h expected 1/1/cafe/80",
                 i, wb_stb, wb_we, wb_wdata, wb_addr);
        miscompares++;
      end
      if (i == 3) wb_stall = 1'b0;
      step();
    end
    vectors++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b1) begin
      $display("FAIL store_wait stb=%b cyc=%b expected 0/1", wb_stb, wb_cyc);
      miscompares++;
    end
    wb_ack = 1'b1;
    step();
    vectors++;
    if (o_dr !== 4'd0 || o_value !== 32'h0 || wb_cyc !== 1'b0) begin
      $display("FAIL store_out dr=%h value=%h cyc=%b expected 0/0/0", o_dr, o_value, wb_cyc);
      miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    preload(4'd9, 32'h55);
    drive_op(5'h14, 4'd2, 32'h102);
    #1;
    vectors++;
    if (wb_cyc !== 1'b0 || o_pipe_stall !== 1'b0) begin
      $display("FAIL mis_nocyc cyc=%b stall=%b expected 0/0", wb_cyc, o_pipe_stall);
      miscompares++;
    end
    step();
    vectors++;
    if (bus_err !== 1'b1 || o_dr !== 4'd0 || o_value !== 32'h0 || wb_cyc !== 1'b0) begin
      $display("FAIL mis_err err=%b dr=%h value=%h cyc=%b expected 1/0/0/0",
               bus_err, o_dr, o_value, wb_cyc);
      miscompares++;
    end
    idle_inputs();
    step();
    vectors++;
    if (bus_err !== 1'b0) begin
      $display("FAIL mis_pulse err=%b expected 0", bus_err);
      miscompares++;
    end
  endtask

  task automatic test_bus_err();
    preload(4'd9, 32'h99);
    drive_op(5'h14, 4'd6, 32'h300);
    step();
    step();
    wb_ack = 1'b1; wb_err = 1'b1; wb_rdata = 32'h77;
    #1;
    vectors++;
    if (of_reg !== 4'd0 || o_pipe_stall !== 1'b0) begin
      $display("FAIL err_fwd reg=%h stall=%b expected 0/0", of_reg, o_pipe_stall);
      miscompares++;
    end
    step();
    vectors++;
    if (bus_err !== 1'b1 || o_dr !== 4'd0 || o_value !== 32'h0) begin
      $display("FAIL err_out err=%b dr=%h value=%h expected 1/0/0", bus_err, o_dr, o_value);
      miscompares++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_flush_req();
    preload(4'd9, 32'h99);
    drive_op(5'h14, 4'd4, 32'h400);
    wb_stall = 1'b1;
    step();
    vectors++;
    if (wb_cyc !== 1'b1) begin
      $display("FAIL flreq_cyc got %b expected 1", wb_cyc);
      miscompares++;
    end
    pipe_flush = 1'b1;
    #1;
    vectors++;
    if (o_pipe_flush !== 1'b1) begin
      $display("FAIL flreq_pass got %b expected 1", o_pipe_flush);
      miscompares++;
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (wb_cyc !== 1'b0 || o_dr !== 4'd0 || o_value !== 32'h0 || o_pipe_stall !== 1'b0) begin
      $display("FAIL flreq_out cyc=%b dr=%h value=%h stall=%b expected 0/0/0/0",
               wb_cyc, o_dr, o_value, o_pipe_stall);
      miscompares++;
    end
  endtask

  task automatic test_flush_wait();
    preload(4'd9, 32'h99);
    drive_op(5'h14, 4'd8, 32'h500);
    step();
    step();
    pipe_flush = 1'b1;
    step();
    pipe_flush = 1'b0;
    vectors++;
    if (wb_cyc !== 1'b1) begin
      $display("FAIL flwait_cyc got %b expected 1", wb_cyc);
      miscompares++;
    end
    wb_ack = 1'b1; wb_rdata = 32'h1111;
    #1;
    vectors++;
    if (of_reg !== 4'd0) begin
      $display("FAIL flwait_fwd reg=%h expected 0", of_reg);
      miscompares++;
    end
    step();
    vectors++;
    if (o_dr !== 4'd0 || o_value !== 32'h0 || wb_cyc !== 1'b0) begin
      $display("FAIL flwait_out dr=%h value=%h cyc=%b expected 0/0/0", o_dr, o_value, wb_cyc);
      miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    preload(4'd9, 32'h5);
    drive_op(5'h14, 4'd10, 32'h600);
    step();
    step();
    pipe_stall = 1'b1; wb_ack = 1'b1; wb_rdata = 32'hABCD;
    step();
    wb_ack = 1'b0; wb_rdata = 32'h0;
    step();
    vectors++;
    if (wb_cyc !== 1'b0 || o_dr !== 4'd9 || o_value !== 32'h5) begin
      $display("FAIL hold_keep cyc=%b dr=%h value=%h expected 0/9/5", wb_cyc, o_dr, o_value);
      miscompares++;
    end
    pipe_stall = 1'b0;
    #1;
    vectors++;
    if (of_reg !== 4'd10 || of_val !== 32'hABCD || o_pipe_stall !== 1'b0) begin
      $display("FAIL hold_fwd reg=%h val=%h stall=%b expected a/abcd/0",
               of_reg, of_val, o_pipe_stall);
      miscompares++;
    end
    step();
    vectors++;
    if (o_dr !== 4'd10 || o_value !== 32'hABCD) begin
      $display("FAIL hold_out dr=%h value=%h expected a/abcd", o_dr, o_value);
      miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    drive_op(5'h14, 4'd11, 32'h700);
    step();
    step();
`ifdef TL45_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wb_cyc !== 1'b1) begin
        $display("FAIL tmo_wait%0d cyc=%b expected 1", i, wb_cyc);
        miscompares++;
      end
      step();
    end
    vectors++;
    if (wb_cyc !== 1'b0 || bus_err !== 1'b1 || o_dr !== 4'd0) begin
      $display("FAIL tmo_fire cyc=%b err=%b dr=%h expected 0/1/0", wb_cyc, bus_err, o_dr);
      miscompares++;
    end
    idle_inputs();
    step();
`else
    for (int i = 0; i < 100; i++) begin
      vectors++;
      if (wb_cyc !== 1'b1) begin
        $display("FAIL notmo_wait%0d cyc=%b expected 1", i, wb_cyc);
        miscompares++;
      end
      step();
    end
    wb_ack = 1'b1; wb_rdata = 32'h5A5A;
    step();
    vectors++;
    if (o_dr !== 4'd11 || o_value !== 32'h5A5A || bus_err !== 1'b0) begin
      $display("FAIL notmo_out dr=%h value=%h err=%b expected b/5a5a/0", o_dr, o_value, bus_err);
      miscompares++;
    end
    idle_inputs();
`endif
  endtask

  task automatic test_async_reset();
    preload(4'd9, 32'h5);
    drive_op(5'h14, 4'd12, 32'h800);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_cyc !== 1'b0 || o_dr !== 4'd0 || o_value !== 32'h0) begin
      $display("FAIL async_rst cyc=%b dr=%h value=%h expected 0/0/0", wb_cyc, o_dr, o_value);
      miscompares++;
    end
    idle_inputs();
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store_stall();
    test_misaligned();
    test_bus_err();
    test_flush_req();
    test_flush_wait();
    test_stall_hold();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
